mem_arbiter: RTL

- Shares one single-ported unified memory between the fetch port (read-only) and the data port (read/write, word/byte) of the 5-stage pipelined CPU.
- Sequences each access through a small FSM with a registered request/acknowledge handshake.
- Breaks ties in favour of the data port, with a starvation limit for fetch.
- Produces per-port stall signals for the pipeline registers.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_starve_ctr.sv | 32 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and grant encodings for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP_IF,
        RESP_DM
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_DM   = 2'b10;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive tie-break losses by the fetch port.
import mem_arb_pkg::*;

module arb_starve_ctr #(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    // A limit of zero still needs a one-bit counter that simply never leaves zero.
    localparam int CW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_STARVE);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != LIMIT)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign at_limit = (count_reg == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports of the pipeline onto one single-ported
// memory, one access at a time, with registered handshakes and stall outputs.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic                  dm_byte,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_byte,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  stall_f,
    output logic                  stall_m,
    output logic [1:0]            gnt
);

    arb_state_t            state_reg;
    logic                  mem_req_reg;
    logic                  mem_we_reg;
    logic                  mem_byte_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic [1:0]            gnt_reg;
    logic                  if_ready_reg;
    logic                  dm_ready_reg;
    logic [DATA_WIDTH-1:0] if_rdata_reg;
    logic [DATA_WIDTH-1:0] dm_rdata_reg;

    logic tie;
    logic grant_if;
    logic at_limit;
    logic starve_inc;
    logic starve_clr;

    // Data wins ties unless fetch has already lost MAX_STARVE of them in a row.
    assign tie        = if_req & dm_req;
    assign grant_if   = if_req & (~dm_req | at_limit);
    assign starve_inc = (state_reg == IDLE) & tie & ~at_limit;
    assign starve_clr = (state_reg == IDLE) & grant_if;

    arb_starve_ctr #(
        .MAX_STARVE(MAX_STARVE)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .at_limit(at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_byte_reg  <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            gnt_reg       <= GNT_NONE;
            if_ready_reg  <= 1'b0;
            dm_ready_reg  <= 1'b0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_if) begin
                        state_reg     <= BUSY_IF;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b0;
                        mem_byte_reg  <= 1'b0;
                        mem_addr_reg  <= if_addr;
                        mem_wdata_reg <= '0;
                        gnt_reg       <= GNT_IF;
                    end else if (dm_req) begin
                        state_reg     <= BUSY_DM;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= dm_we;
                        mem_byte_reg  <= dm_byte;
                        mem_addr_reg  <= dm_addr;
                        mem_wdata_reg <= dm_wdata;
                        gnt_reg       <= GNT_DM;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        state_reg    <= RESP_IF;
                        mem_req_reg  <= 1'b0;
                        gnt_reg      <= GNT_NONE;
                        if_rdata_reg <= mem_rdata;
                        if_ready_reg <= 1'b1;
                    end
                end
                BUSY_DM: begin
                    if (mem_ack) begin
                        state_reg    <= RESP_DM;
                        mem_req_reg  <= 1'b0;
                        gnt_reg      <= GNT_NONE;
                        dm_ready_reg <= 1'b1;
                        // Writes leave the last read result visible to the pipeline.
                        if (!mem_we_reg) begin
                            dm_rdata_reg <= mem_rdata;
                        end
                    end
                end
                RESP_IF, RESP_DM: begin
                    state_reg    <= IDLE;
                    if_ready_reg <= 1'b0;
                    dm_ready_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_byte  = mem_byte_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign gnt       = gnt_reg;
    assign if_ready  = if_ready_reg;
    assign dm_ready  = dm_ready_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign stall_f   = if_req & ~if_ready_reg;
    assign stall_m   = dm_req & ~dm_ready_reg;

endmodule
